// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Alignment and funct3 legality; the range check lives in the top.
    function automatic logic f3_align_err(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic e;
        e = 1'b0;
        case (f3)
            F3_LB:   e = 1'b0;
            F3_LH:   e = lo[0];
            F3_LW:   e = |lo;
            F3_LBU:  e = we;
            F3_LHU:  e = we | lo[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = old_word[7:0];
            2'd1:    byte_sel = old_word[15:8];
            2'd2:    byte_sel = old_word[23:16];
            default: byte_sel = old_word[31:24];
        endcase
        half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        load_data = old_word;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = old_word;
        endcase
    end

    // Only the addressed lane is replaced; every other byte is kept.
    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_LB: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_LH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores over a word-only memory port.
// Optional LSU_STATS_EN adds successful load/store counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
`ifdef LSU_STATS_EN
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
`endif
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q;
    logic        accept;
    logic        range_err;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept    = req_valid & req_ready;
    assign range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign req_err   = range_err | f3_align_err(req_we, req_funct3, req_addr[1:0]);

    // Old word comes straight from the memory during READ.
    lsu_lane_align u_lane (
        .funct3     (req_q.funct3),
        .addr_lo    (req_q.addr_lo),
        .old_word   (mem_RD),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                          state_d = S_RESP;
                    else if (req_we && req_funct3 == F3_LW) state_d = S_WRITE;
                    else                                  state_d = S_READ;
                end
            end
            S_READ:  state_d = req_q.we ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs, driven from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_A      <= '0;
            mem_WD     <= '0;
            mem_WE     <= 1'b0;
        end else begin
            req_ready  <= (state_d == S_IDLE);
            resp_valid <= (state_d == S_RESP);
            mem_WE     <= (state_d == S_WRITE);
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_A      <= '0;
            mem_WD     <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_q <= '{we: req_we, funct3: req_funct3,
                                   addr_lo: req_addr[1:0], wdata: req_wdata};
                        if (req_err) begin
                            resp_err <= 1'b1;
                        end else begin
                            mem_A <= 32'(req_addr[IDX_W+1:2]);
                            if (req_we) mem_WD <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (req_q.we) begin
                        mem_A  <= mem_A;
                        mem_WD <= store_word;
                    end else begin
                        resp_rdata <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
        end else if (state_q == S_RESP && !resp_err) begin
            if (req_q.we) stat_stores <= stat_stores + 32'd1;
            else          stat_loads  <= stat_loads + 32'd1;
        end
    end
`endif

endmodule
